seu_pipe: RTL

- Parametrised, pipelined immediate/sign-extension unit for the LEGv8 datapath; successor to the single-cycle combinational SEU.
- Takes the 26-bit instruction payload and an extend-op code, and produces an extended immediate of width DATA_W.
- One output register stage plus a one-entry skid buffer with valid/ready handshakes on both sides, so it can sit between decode and execute in pipelined builds.
- Adds a wide-immediate (MOVZ-style) mode, an illegal-op error flag and a sideband tag passthrough.

---
 rtl/seu_pipe.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seu_pipe.sv
// ---------------------------------------------------------------------------
// seu_pipe -- pipelined immediate / sign-extension unit for the LEGv8 datapath.
//
// Decodes the immediate field selected by seu_op out of a 26-bit instruction
// payload and delivers it, extended to DATA_W bits, through one output
// register stage backed by a one-entry skid buffer. Both sides use
// valid/ready handshakes, so the unit can sit between decode and execute.
//
// Optional feature macro: SEU_WIDE_IMM_EN
//   defined     -> op 3'b100 builds the MOVZ-style wide immediate
//                  (imm16 << 16*hw).
//   not defined -> op 3'b100 is illegal (result 0, out_err=1); no shifter.
//
// Parameters:
//   DATA_W  width of the extended result (32 or 64).
//   TAG_W   width of the sideband tag carried with each result.
//
// Ports:
//   clk               system clock, all state on the rising edge
//   reset             synchronous, active-high reset
//   in_valid          input beat valid
//   in_ready          unit can accept an input beat this cycle (registered)
//   instruction[25:0] instruction payload
//   seu_op[2:0]       extend mode: 000 I, 001 D, 010 B, 011 CB, 100 IW
//   in_tag            sideband tag for the input beat
//   out_valid         result beat valid
//   out_ready         downstream accepts the result this cycle
//   extended_address  extended immediate
//   out_tag           tag of the current result
//   out_err           current result came from an illegal/out-of-range op
// ---------------------------------------------------------------------------
module seu_pipe #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       instruction,
  input  logic [2:0]        seu_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] extended_address,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  // Result is formed at 64 bits and then cut to DATA_W, so the same
  // sign-extension expressions serve both legal widths.
  // Returns {err, result}.
  function automatic logic [DATA_W:0] seu_extend(input logic [25:0] instr,
                                                 input logic [2:0]  op);
    logic [63:0] wide_v;
    logic        err_v;
    wide_v = 64'd0;
    err_v  = 1'b0;
    case (op)
      3'b000: wide_v = {52'd0, instr[21:10]};
      3'b001: wide_v = {{55{instr[20]}}, instr[20:12]};
      3'b010: wide_v = {{36{instr[25]}}, instr[25:0], 2'b00};
      3'b011: wide_v = {{43{instr[23]}}, instr[23:5], 2'b00};
`ifdef SEU_WIDE_IMM_EN
      3'b100: begin
        // hw>=2 places the half-word above bit 31, which a 32-bit
        // result cannot represent.
        if ((DATA_W == 32) && instr[22]) begin
          wide_v = 64'd0;
          err_v  = 1'b1;
        end else begin
          wide_v = {48'd0, instr[20:5]} << {instr[22:21], 4'b0000};
          err_v  = 1'b0;
        end
      end
`endif
      default: begin
        wide_v = 64'd0;
        err_v  = 1'b1;
      end
    endcase
    return {err_v, wide_v[DATA_W-1:0]};
  endfunction

  // Main slot drives the outputs; skid slot absorbs one beat under stall.
  logic              main_valid_r;
  logic [DATA_W-1:0] main_data_r;
  logic [TAG_W-1:0]  main_tag_r;
  logic              main_err_r;
  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [TAG_W-1:0]  skid_tag_r;
  logic              skid_err_r;
  logic              in_ready_r;

  logic              main_valid_n_s;
  logic [DATA_W-1:0] main_data_n_s;
  logic [TAG_W-1:0]  main_tag_n_s;
  logic              main_err_n_s;
  logic              skid_valid_n_s;
  logic [DATA_W-1:0] skid_data_n_s;
  logic [TAG_W-1:0]  skid_tag_n_s;
  logic              skid_err_n_s;

  logic [DATA_W:0]   ext_s;
  logic              in_xfer_s;
  logic              out_xfer_s;

  // Decode the incoming beat's immediate and the handshake transfers.
  always_comb begin
    ext_s      = seu_extend(instruction, seu_op);
    in_xfer_s  = in_valid & in_ready_r;
    out_xfer_s = main_valid_r & out_ready;
  end

  // Next-state of the main and skid slots.
  always_comb begin
    main_valid_n_s = main_valid_r;
    main_data_n_s  = main_data_r;
    main_tag_n_s   = main_tag_r;
    main_err_n_s   = main_err_r;
    skid_valid_n_s = skid_valid_r;
    skid_data_n_s  = skid_data_r;
    skid_tag_n_s   = skid_tag_r;
    skid_err_n_s   = skid_err_r;
    if (skid_valid_r) begin
      // in_ready is low here, so only the output side can move.
      if (out_xfer_s) begin
        main_valid_n_s = 1'b1;
        main_data_n_s  = skid_data_r;
        main_tag_n_s   = skid_tag_r;
        main_err_n_s   = skid_err_r;
        skid_valid_n_s = 1'b0;
      end else begin
        skid_valid_n_s = 1'b1;
      end
    end else if (in_xfer_s) begin
      if (!main_valid_r || out_xfer_s) begin
        // Main is empty or draining this cycle: new beat goes straight in.
        main_valid_n_s = 1'b1;
        main_data_n_s  = ext_s[DATA_W-1:0];
        main_tag_n_s   = in_tag;
        main_err_n_s   = ext_s[DATA_W];
      end else begin
        // Main is stalled: park the beat in the skid slot.
        skid_valid_n_s = 1'b1;
        skid_data_n_s  = ext_s[DATA_W-1:0];
        skid_tag_n_s   = in_tag;
        skid_err_n_s   = ext_s[DATA_W];
      end
    end else if (out_xfer_s) begin
      main_valid_n_s = 1'b0;
    end else begin
      main_valid_n_s = main_valid_r;
    end
  end

  // Slot registers and the registered in_ready; reset discards all beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {DATA_W{1'b0}};
      main_tag_r   <= {TAG_W{1'b0}};
      main_err_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_W{1'b0}};
      skid_tag_r   <= {TAG_W{1'b0}};
      skid_err_r   <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      main_valid_r <= main_valid_n_s;
      main_data_r  <= main_data_n_s;
      main_tag_r   <= main_tag_n_s;
      main_err_r   <= main_err_n_s;
      skid_valid_r <= skid_valid_n_s;
      skid_data_r  <= skid_data_n_s;
      skid_tag_r   <= skid_tag_n_s;
      skid_err_r   <= skid_err_n_s;
      in_ready_r   <= ~skid_valid_n_s;
    end
  end

  assign in_ready         = in_ready_r;
  assign out_valid        = main_valid_r;
  assign extended_address = main_data_r;
  assign out_tag          = main_tag_r;
  assign out_err          = main_err_r;

endmodule
